// File: rtl/pixel_frame_writer.sv
// Packs an RGB pixel stream into a little-endian BMP byte stream (B,G,R order),
// buffers 32-bit words in a small FIFO, and flags the last word of every frame.
module pixel_frame_writer #(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  J_R,
  input  logic [7:0]  J_G,
  input  logic [7:0]  J_B,
  input  logic        output_valid,
  output logic        pix_ready,
  output logic [31:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        frame_done,
  output logic        drop_err
);

  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int CW          = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int RW          = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int FRAME_WORDS = IMG_WIDTH * IMG_HEIGHT * 3 / 4;
  localparam int WW          = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

  localparam logic [AW:0]   FULL      = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [WW-1:0] WORD_LAST = WW'(FRAME_WORDS - 1);

  logic [1:0]    phase_q, phase_d;
  logic [23:0]   acc_q, acc_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [WW-1:0] word_cnt_q, word_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          pix_ready_q, pix_ready_d;
  logic          drop_err_q, drop_err_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic          accept, push, pop;
  logic [31:0]   push_word;

  // Byte packer: the accumulator holds the bytes not yet forming a full word.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    phase_d   = phase_q;
    acc_d     = acc_q;
    push      = 1'b0;
    push_word = '0;
    accept    = output_valid && pix_ready_q;
    if (accept) begin
      phase_d = phase_q + 2'd1;
      case (phase_q)
        2'd0: acc_d = {J_R, J_G, J_B};
        2'd1: begin
          push_word = {J_B, acc_q};
          acc_d     = {8'h00, J_R, J_G};
          push      = 1'b1;
        end
        2'd2: begin
          push_word = {J_G, J_B, acc_q[15:0]};
          acc_d     = {16'h0000, J_R};
          push      = 1'b1;
        end
        default: begin
          push_word = {J_R, J_G, J_B, acc_q[7:0]};
          acc_d     = '0;
          push      = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    wr_valid   = (count_q != '0);
    pop        = wr_valid && wr_ready;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    // Readiness reflects occupancy after this edge, never the same-cycle pop.
    pix_ready_d = (count_d != FULL);
    drop_err_d  = drop_err_q || (output_valid && !pix_ready_q);

    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    word_cnt_d = word_cnt_q;
    if (pop) word_cnt_d = (word_cnt_q == WORD_LAST) ? '0 : word_cnt_q + WW'(1);
  end

  assign pix_ready  = pix_ready_q;
  assign drop_err   = drop_err_q;
  assign wr_data    = mem_q[rd_ptr_q];
  assign frame_done = pop && (word_cnt_q == WORD_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q     <= '0;
      acc_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      word_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pix_ready_q <= 1'b0;
      drop_err_q  <= 1'b0;
      // NOTE: the buffer is reset so wr_data reads zero out of reset; this costs
      // a reset on each storage flop and rules out a RAM macro here.
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      phase_q     <= phase_d;
      acc_q       <= acc_d;
      col_q       <= col_d;
      row_q       <= row_d;
      word_cnt_q  <= word_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pix_ready_q <= pix_ready_d;
      drop_err_q  <= drop_err_d;
      if (push) mem_q[wr_ptr_q] <= push_word;
    end
  end

endmodule
